// File: rtl/pong_pkg.sv
// Shared types for the pong match datapath: FSM state encoding,
// score width and the player index used by the winner flag.
package pong_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        OVER  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

endpackage

// File: rtl/pong_tick_div.sv
// Free-running clk divider producing a one-cycle tick every TICK_DIV cycles,
// with synchronous clear and a freeze that holds the count in place.
module pong_tick_div #(
    parameter int TICK_DIV = 416667
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic freeze,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = !freeze && (cnt == LAST);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve hold, ball pacing, scoring and winner detection.
// Optional pause input and PAUSE state are built with PONG_CTRL_PAUSE_EN.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 416667,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               point_1,
    input  logic               point_2,
`ifdef PONG_CTRL_PAUSE_EN
    input  logic               pause,
`endif
    output logic               ball_rst,
    output logic               ball_tick,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int SW = $clog2(SERVE_TICKS + 1);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_LAST = SCORE_W'(WIN_SCORE - 1);

    state_t state_q, state_d;

    logic start_q, p1_q, p2_q;
    logic start_ev, p1_ev, p2_ev, pause_ev;
    logic tick_int, div_clear, div_freeze;
    logic [SW-1:0] serve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
        end else begin
            start_q <= start;
            p1_q    <= point_1;
            p2_q    <= point_2;
        end
    end

    assign start_ev = start & ~start_q;
    assign p1_ev    = point_1 & ~p1_q;
    assign p2_ev    = point_2 & ~p2_q;

`ifdef PONG_CTRL_PAUSE_EN
    logic pause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pause_q <= 1'b0;
        else       pause_q <= pause;
    end

    assign pause_ev = pause & ~pause_q;
`else
    assign pause_ev = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_ev) state_d = SERVE;
            SERVE: if (tick_int && serve_cnt == SERVE_LAST) state_d = PLAY;
            PLAY: begin
                if (p1_ev)
                    state_d = (score_1 == WIN_LAST) ? OVER : SERVE;
                else if (p2_ev)
                    state_d = (score_2 == WIN_LAST) ? OVER : SERVE;
                else if (pause_ev)
                    state_d = PAUSE;
            end
            OVER:  if (start_ev) state_d = SERVE;
            PAUSE: if (pause_ev) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ball_rst  = 1'b1;
        game_over = 1'b0;
        unique case (state_q)
            PLAY, PAUSE: ball_rst  = 1'b0;
            OVER:        game_over = 1'b1;
            default:     ball_rst  = 1'b1;
        endcase
    end

    assign state = state_q;

    // Entering or leaving PAUSE keeps the count so play resumes mid-period
    assign div_freeze = (state_q == PAUSE);
    assign div_clear  = (state_d != state_q)
                      && !(state_q == PLAY  && state_d == PAUSE)
                      && !(state_q == PAUSE && state_d == PLAY);

    pong_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (div_clear),
        .freeze (div_freeze),
        .tick   (tick_int)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serve_cnt <= '0;
        end else if (state_q != SERVE || state_d != SERVE) begin
            serve_cnt <= '0;
        end else if (tick_int) begin
            serve_cnt <= serve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_1 <= '0;
            score_2 <= '0;
            winner  <= PLAYER_1;
        end else begin
            unique case (state_q)
                IDLE, OVER: begin
                    if (start_ev) begin
                        score_1 <= '0;
                        score_2 <= '0;
                    end
                end
                PLAY: begin
                    if (p1_ev) begin
                        score_1 <= score_1 + 1'b1;
                        if (state_d == OVER) winner <= PLAYER_1;
                    end else if (p2_ev) begin
                        score_2 <= score_2 + 1'b1;
                        if (state_d == OVER) winner <= PLAYER_2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered so the pulse never leaks into the state that follows PLAY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ball_tick <= 1'b0;
        else       ball_tick <= tick_int && state_q == PLAY && state_d == PLAY;
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl (TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3).
// Pause checks are compiled in with PONG_CTRL_PAUSE_EN.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, point_1, point_2;
`ifdef PONG_CTRL_PAUSE_EN
    logic       pause;
`endif
    logic       ball_rst, ball_tick, game_over, winner;
    logic [3:0] score_1, score_2;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .TICK_DIV    (4),
        .SERVE_TICKS (2),
        .WIN_SCORE   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .point_1   (point_1),
        .point_2   (point_2),
`ifdef PONG_CTRL_PAUSE_EN
        .pause     (pause),
`endif
        .ball_rst  (ball_rst),
        .ball_tick (ball_tick),
        .score_1   (score_1),
        .score_2   (score_2),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    typedef struct {
        bit st, p1, p2;
        int adv;
        int e_state, e_rst, e_tick, e_s1, e_s2, e_go, e_win;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " state"}, int'(state), v.e_state);
        check({tag, " ball_rst"}, int'(ball_rst), v.e_rst);
        check({tag, " ball_tick"}, int'(ball_tick), v.e_tick);
        check({tag, " score_1"}, int'(score_1), v.e_s1);
        check({tag, " score_2"}, int'(score_2), v.e_s2);
        check({tag, " game_over"}, int'(game_over), v.e_go);
        if (v.e_go == 1) check({tag, " winner"}, int'(winner), v.e_win);
    endtask

    initial begin
        // start p1 p2 adv | state rst tick s1 s2 go win
        vecs[0]  = '{1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 7,  1, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 3,  2, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 1,  2, 0, 1, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 3,  2, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 1,  1, 1, 0, 1, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, 8,  2, 0, 0, 1, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 11, 2, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 1,  2, 0, 1, 1, 0, 0, 0};
        vecs[11] = '{0, 1, 1, 1,  1, 1, 0, 2, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 8,  2, 0, 0, 2, 0, 0, 0};
        vecs[13] = '{0, 0, 1, 1,  1, 1, 0, 2, 1, 0, 0};
        vecs[14] = '{0, 0, 0, 8,  2, 0, 0, 2, 1, 0, 0};
        vecs[15] = '{0, 0, 1, 1,  1, 1, 0, 2, 2, 0, 0};
        vecs[16] = '{0, 0, 0, 8,  2, 0, 0, 2, 2, 0, 0};
        vecs[17] = '{0, 0, 1, 1,  3, 1, 0, 2, 3, 1, 1};
        vecs[18] = '{0, 1, 1, 10, 3, 1, 0, 2, 3, 1, 1};
        vecs[19] = '{1, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0};
        vecs[20] = '{0, 0, 0, 8,  2, 0, 0, 0, 0, 0, 0};
        vecs[21] = '{0, 1, 0, 1,  1, 1, 0, 1, 0, 0, 0};
        vecs[22] = '{0, 0, 1, 8,  2, 0, 0, 1, 0, 0, 0};
        vecs[23] = '{0, 0, 1, 1,  2, 0, 0, 1, 0, 0, 0};

        reset   = 1'b1;
        start   = 1'b0;
        point_1 = 1'b0;
        point_2 = 1'b0;
`ifdef PONG_CTRL_PAUSE_EN
        pause   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset state", int'(state), 0);
        check("reset ball_rst", int'(ball_rst), 1);
        check("reset ball_tick", int'(ball_tick), 0);
        check("reset score_1", int'(score_1), 0);
        check("reset score_2", int'(score_2), 0);
        check("reset game_over", int'(game_over), 0);
        check("reset winner", int'(winner), 0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            start   = vecs[i].st;
            point_1 = vecs[i].p1;
            point_2 = vecs[i].p2;
            repeat (vecs[i].adv) @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset two cycles into PLAY with a nonzero score
        @(negedge clk);
        check("pre-reset state", int'(state), 2);
        check("pre-reset score_1", int'(score_1), 1);
        reset = 1'b1;
        #1;
        check("async state", int'(state), 0);
        check("async score_1", int'(score_1), 0);
        check("async ball_rst", int'(ball_rst), 1);
        check("async ball_tick", int'(ball_tick), 0);
        check("async game_over", int'(game_over), 0);
        @(negedge clk);
        check("held reset state", int'(state), 0);
        point_2 = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

`ifdef PONG_CTRL_PAUSE_EN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pause play entry", int'(state), 2);
        repeat (2) @(negedge clk);
        pause = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check($sformatf("paused state c%0d", k), int'(state), 4);
            check($sformatf("paused tick c%0d", k), int'(ball_tick), 0);
            check($sformatf("paused rst c%0d", k), int'(ball_rst), 0);
        end
        pause = 1'b0;
        @(negedge clk);
        check("pause release state", int'(state), 4);
        pause = 1'b1;
        @(negedge clk);
        check("resume state", int'(state), 2);
        check("resume tick0", int'(ball_tick), 0);
        @(negedge clk);
        check("resume tick1", int'(ball_tick), 1);
        pause = 1'b0;
        @(negedge clk);
        check("resume tick2", int'(ball_tick), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
